// File: rtl/dcache_pkg.sv
// Shared constants and types for the TL-stage data cache controller.
package dcache_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_W = 3'b010;

  localparam int LINE_BYTES    = 16;
  localparam int OFFSET_W      = $clog2(LINE_BYTES);
  localparam int NUM_LINES_DEF = 4;
  localparam int INDEX_W       = $clog2(NUM_LINES_DEF);
  localparam int TAG_W         = 32 - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

endpackage

// File: rtl/tl_dcache_ctrl_if.sv
// Line-granular memory port between the data cache and the memory system.
interface tl_dcache_ctrl_if;

  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i;
  logic         mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );

endinterface

// File: rtl/dcache_array.sv
// Register-based valid/dirty/tag/data storage for a direct-mapped cache.
module dcache_array #(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = 2,
  parameter int TAG_W     = 26,
  parameter int LINE_W    = 128
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [IDX_W-1:0]    i_idx,
  output logic                o_valid,
  output logic                o_dirty,
  output logic [TAG_W-1:0]    o_tag,
  output logic [LINE_W-1:0]   o_data,
  input  logic                i_wr_en,
  input  logic [LINE_W/8-1:0] i_wr_be,
  input  logic [LINE_W-1:0]   i_wr_data,
  input  logic                i_fill_en,
  input  logic [TAG_W-1:0]    i_fill_tag,
  input  logic [LINE_W-1:0]   i_fill_data,
  input  logic                i_clean_en
);

  localparam int unsigned NB = LINE_W / 8;

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_clean_en) begin
      r_dirty[i_idx] <= 1'b0;
    end else if (i_wr_en) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: valid gates every use of them.
  always_ff @(posedge i_clk) begin
    if (i_fill_en) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_data;
    end else if (i_wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (i_wr_be[b]) r_data[i_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/tl_dcache_ctrl.sv
// TL-stage data cache: direct-mapped, write-back, write-allocate lookup with
// pipeline stall and a write-back/refill sequencer on the line memory port.
module tl_dcache_ctrl #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             tl_cache_addr_i,
  input  logic [31:0]             tl_store_data_i,
  input  logic [31:0]             tl_instruction_i,
  input  logic                    tl_int_write_enable_i,
  output logic                    stall_core_o,
  output logic [31:0]             tl_load_data_o,
  output logic                    wb_int_write_enable_o,
  tl_dcache_ctrl_if.master        mem
);

  import dcache_pkg::*;

  localparam int OW = $clog2(LINE_BYTES);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 32 - OW - IW;
  localparam int LW = LINE_BYTES * 8;

  state_t r_state;
  state_t w_next;

  logic          w_is_load, w_is_store, w_access, w_is_byte, w_hit;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [OW-1:0] w_off;
  logic [OW-3:0] w_word_sel;
  logic [1:0]    w_bsel;
  logic          w_valid, w_dirty;
  logic [TW-1:0] w_vtag;
  logic [LW-1:0] w_line;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic          w_wr_en, w_fill_en, w_clean_en;
  logic [LINE_BYTES-1:0] w_be;
  logic [LW-1:0] w_wr_data;
  logic          w_unused;

  assign w_is_load  = tl_instruction_i[6:0] == OPC_LOAD;
  assign w_is_store = tl_instruction_i[6:0] == OPC_STORE;
  assign w_access   = w_is_load || w_is_store;
  assign w_is_byte  = tl_instruction_i[14:12] == F3_B;
  assign w_unused   = ^{tl_instruction_i[31:15], tl_instruction_i[11:7]};

  assign w_off      = tl_cache_addr_i[OW-1:0];
  assign w_word_sel = w_off[OW-1:2];
  assign w_bsel     = w_off[1:0];
  assign w_idx      = tl_cache_addr_i[OW+IW-1:OW];
  assign w_tag      = tl_cache_addr_i[31:OW+IW];

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IW),
    .TAG_W     (TW),
    .LINE_W    (LW)
  ) u_array (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_idx       (w_idx),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_vtag),
    .o_data      (w_line),
    .i_wr_en     (w_wr_en),
    .i_wr_be     (w_be),
    .i_wr_data   (w_wr_data),
    .i_fill_en   (w_fill_en),
    .i_fill_tag  (w_tag),
    .i_fill_data (mem.mem_rdata_i),
    .i_clean_en  (w_clean_en)
  );

  assign w_hit        = w_access && w_valid && (w_vtag == w_tag);
  assign stall_core_o = (r_state != IDLE) || (w_access && !w_hit);
  assign wb_int_write_enable_o = tl_int_write_enable_i && !stall_core_o;

  assign w_word = w_line[{w_word_sel, 5'b0} +: 32];
  assign w_byte = w_word[{w_bsel, 3'b0} +: 8];
  assign tl_load_data_o = (w_is_load && !stall_core_o) ?
                          (w_is_byte ? {{24{w_byte[7]}}, w_byte} : w_word) : '0;

  // Store data is replicated across the line; the byte enables pick the lane.
  assign w_wr_en    = (r_state == IDLE) && w_is_store && w_hit;
  assign w_be       = w_is_byte ? (LINE_BYTES'(1) << w_off)
                                : (LINE_BYTES'(4'hF) << {w_word_sel, 2'b00});
  assign w_wr_data  = w_is_byte ? {LINE_BYTES{tl_store_data_i[7:0]}}
                                : {(LINE_BYTES/4){tl_store_data_i}};
  assign w_fill_en  = (r_state == FILL) && mem.mem_ack_i;
  assign w_clean_en = (r_state == WB) && mem.mem_ack_i;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_access && !w_hit) w_next = (w_valid && w_dirty) ? WB : FILL;
      WB:   if (mem.mem_ack_i) w_next = FILL;
      FILL: if (mem.mem_ack_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.mem_addr_o  = '0;
    mem.mem_wdata_o = '0;
    unique case (r_state)
      WB: begin
        mem.mem_req_o   = 1'b1;
        mem.mem_we_o    = 1'b1;
        mem.mem_addr_o  = {w_vtag, w_idx, {OW{1'b0}}};
        mem.mem_wdata_o = w_line;
      end
      FILL: begin
        mem.mem_req_o  = 1'b1;
        mem.mem_addr_o = {w_tag, w_idx, {OW{1'b0}}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tl_dcache_ctrl.sv
// Scoreboard bench for tl_dcache_ctrl with a behavioural line memory and a
// flat word-level reference memory.
module tb_tl_dcache_ctrl;

  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, sdata, instr;
  logic        int_we;
  logic        stall;
  logic [31:0] ld;
  logic        wb_we;

  tl_dcache_ctrl_if u_mem();

  tl_dcache_ctrl #(
    .NUM_LINES  (4),
    .LINE_BYTES (16)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .tl_cache_addr_i       (addr),
    .tl_store_data_i       (sdata),
    .tl_instruction_i      (instr),
    .tl_int_write_enable_i (int_we),
    .stall_core_o          (stall),
    .tl_load_data_o        (ld),
    .wb_int_write_enable_o (wb_we),
    .mem                   (u_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } req_t;

  int n_tests = 0;
  int n_fail  = 0;
  int lat = 1;
  bit hold_fill = 1'b0;
  int late_req = 0;
  int late_done = 0;

  logic [31:0]  sb_q[$];
  req_t         log_q[$];
  logic [127:0] mem_line [logic [31:0]];
  logic [31:0]  gold     [logic [31:0]];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0, f3, 5'h0, op};
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    case (wa)
      32'h40:  return 32'hAAAAAAAA;
      32'h44:  return 32'hBBBBBBBB;
      32'h48:  return 32'hCCCCCCCC;
      32'h4C:  return 32'hDDDDDDDD;
      default: return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
    endcase
  endfunction

  function automatic logic [127:0] get_line(input logic [31:0] la);
    if (mem_line.exists(la)) return mem_line[la];
    return {init_word(la + 12), init_word(la + 8), init_word(la + 4), init_word(la)};
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] wa);
    if (gold.exists(wa)) return gold[wa];
    return init_word(wa);
  endfunction

  task automatic gold_store(input bit is_byte, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] wa, w;
    wa = a & 32'hFFFF_FFFC;
    w  = gold_rd(wa);
    if (is_byte) w[{a[1:0], 3'b0} +: 8] = d[7:0];
    else         w = d;
    gold[wa] = w;
  endtask

  function automatic logic [31:0] gold_lb(input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    w = gold_rd(a & 32'hFFFF_FFFC);
    b = w[{a[1:0], 3'b0} +: 8];
    return {{24{b[7]}}, b};
  endfunction

  // Memory responder: acks each request after 'lat' cycles; fills can be held.
  initial begin
    int cnt = 0;
    logic [31:0]  st_addr;
    logic [127:0] st_wd;
    req_t r;
    u_mem.mem_ack_i   = 1'b0;
    u_mem.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      u_mem.mem_ack_i = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (late_req != late_done) begin
        late_done++;
        u_mem.mem_rdata_i = '1;
        u_mem.mem_ack_i   = 1'b1;
      end else if (u_mem.mem_req_o && !(hold_fill && !u_mem.mem_we_o)) begin
        if (cnt == 0) begin
          st_addr = u_mem.mem_addr_o;
          st_wd   = u_mem.mem_wdata_o;
        end
        cnt++;
        if (cnt >= lat) begin
          check("mem_addr_stable", u_mem.mem_addr_o, st_addr);
          if (u_mem.mem_we_o) check("mem_wdata_stable", u_mem.mem_wdata_o, st_wd);
          r.we = u_mem.mem_we_o;
          r.addr = u_mem.mem_addr_o;
          r.wdata = u_mem.mem_wdata_o;
          log_q.push_back(r);
          if (u_mem.mem_we_o) mem_line[u_mem.mem_addr_o] = u_mem.mem_wdata_o;
          else                u_mem.mem_rdata_i = get_line(u_mem.mem_addr_o);
          u_mem.mem_ack_i = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && instr[6:0] == OPC_LOAD && !stall) begin
      if (sb_q.size() == 0) check("sb_underflow", 1, 0);
      else                  check("load_data", ld, sb_q.pop_front());
    end
  end

  task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input int exp_stalls);
    int n = 0;
    bit done = 1'b0;
    @(posedge clk);
    #1;
    instr  = ins;
    addr   = a;
    sdata  = d;
    int_we = (ins[6:0] == OPC_LOAD);
    if (ins[6:0] == OPC_LOAD) sb_q.push_back(exp);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        if (n == 0) begin
          check("ld_zero_stalled", ld, 0);
          check("wb_we_stalled", wb_we, 0);
        end
        n++;
      end else begin
        done = 1'b1;
        check("wb_we_pass", wb_we, int_we);
      end
    end
    if (!done) check("op_timeout", 0, 1);
    if (exp_stalls >= 0) check("stall_cycles", n, exp_stalls);
    @(posedge clk);
    #1;
    instr  = mk(7'b0110011, 3'b000);
    int_we = 1'b0;
  endtask

  localparam logic [31:0] LW_I  = 32'h0000_2003;
  localparam logic [31:0] LB_I  = 32'h0000_0003;
  localparam logic [31:0] SW_I  = 32'h0000_2023;
  localparam logic [31:0] SB_I  = 32'h0000_0023;
  localparam logic [31:0] NOP_I = 32'h0000_0033;

  initial begin
    rst = 1'b1; instr = NOP_I; addr = '0; sdata = '0; int_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_req", u_mem.mem_req_o, 0);
    check("rst_we", u_mem.mem_we_o, 0);
    check("rst_addr", u_mem.mem_addr_o, 0);
    check("rst_wdata", u_mem.mem_wdata_o, 0);
    check("rst_ld", ld, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Cold load: clean miss -> FILL at 0x40.
    lat = 2;
    log_q.delete();
    run_op(LW_I, 32'h40, 0, 32'hAAAAAAAA, 1 + 2);
    check("cold_nreq", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("cold_we", log_q[0].we, 0);
      check("cold_addr", log_q[0].addr, 32'h40);
    end

    lat = 1;
    gold_store(1'b0, 32'h44, 32'h12345678);
    run_op(SW_I, 32'h44, 32'h12345678, 0, 0);
    run_op(LW_I, 32'h44, 0, 32'h12345678, 0);

    // Conflict miss with a dirty victim: WB 0x40 then FILL 0x140.
    lat = 2;
    log_q.delete();
    run_op(LW_I, 32'h144, 0, init_word(32'h144), 1 + 2 * 2);
    check("wb_nreq", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("wb_we", log_q[0].we, 1);
      check("wb_addr", log_q[0].addr, 32'h40);
      check("wb_word1", log_q[0].wdata[63:32], 32'h12345678);
      check("wb_word0", log_q[0].wdata[31:0], 32'hAAAAAAAA);
      check("fill_we", log_q[1].we, 0);
      check("fill_addr", log_q[1].addr, 32'h140);
    end

    gold_store(1'b1, 32'h47, 32'h80);
    run_op(SB_I, 32'h47, 32'h80, 0, 1 + 2);
    run_op(LB_I, 32'h47, 0, 32'hFFFFFF80, 0);
    gold_store(1'b1, 32'h45, 32'h7F);
    run_op(SB_I, 32'h45, 32'h7F, 0, 0);
    run_op(LW_I, 32'h44, 0, 32'h80347F78, 0);
    run_op(LW_I, 32'h40, 0, 32'hAAAAAAAA, 0);
    run_op(LB_I, 32'h44, 0, 32'h00000078, 0);

    @(posedge clk);
    #1 instr = NOP_I; int_we = 1'b1;
    @(negedge clk);
    check("nop_stall", stall, 0);
    check("nop_wb_we", wb_we, 1);
    check("nop_req", u_mem.mem_req_o, 0);
    check("nop_ld", ld, 0);
    @(posedge clk);
    #1 int_we = 1'b0;

    // Reset while the FILL for 0x80 is outstanding.
    lat = 1;
    hold_fill = 1'b1;
    instr = LW_I; addr = 32'h80;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        if (u_mem.mem_req_o && !u_mem.mem_we_o) seen = 1'b1;
      end
      check("fill_reached", seen, 1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; instr = NOP_I;
    @(negedge clk);
    check("rstfill_req", u_mem.mem_req_o, 0);
    check("rstfill_stall", stall, 0);
    late_req++;
    repeat (3) @(negedge clk);
    check("late_ack_req", u_mem.mem_req_o, 0);
    check("late_ack_stall", stall, 0);
    hold_fill = 1'b0;
    log_q.delete();
    run_op(LW_I, 32'h44, 0, 32'h80347F78, 1 + 1);
    check("post_rst_nreq", log_q.size(), 1);
    if (log_q.size() >= 1) check("post_rst_addr", log_q[0].addr, 32'h40);

    for (int i = 0; i < 40; i++) begin
      int          k;
      logic [31:0] a, d;
      lat = $urandom_range(1, 3);
      k   = $urandom_range(0, 4);
      a   = $urandom_range(0, 255);
      d   = $urandom;
      case (k)
        0: run_op(LW_I, a & 32'hFC, 0, gold_rd(a & 32'hFC), -1);
        1: run_op(LB_I, a, 0, gold_lb(a), -1);
        2: begin gold_store(1'b0, a & 32'hFC, d); run_op(SW_I, a & 32'hFC, d, 0, -1); end
        3: begin gold_store(1'b1, a, d); run_op(SB_I, a, d, 0, -1); end
        default: run_op(NOP_I, a, d, 0, 0);
      endcase
    end

    repeat (2) @(posedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
